pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time in SysClk cycles. It is the receive-side counterpart to the pwm generator, used for loopback self-test of generator output and for decoding external PWM sensor and servo feedback. The block synchronizes the input, detects edges, times each full cycle, and flags stuck or overly long inputs.

---
 rtl/pwm_capture.sv | 107 ++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes PwmIn, times rising-to-rising and rising-to-falling
// intervals in SysClk cycles, and flags inputs that stop toggling.
module pwm_capture #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             SysClk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             PwmIn,
   output logic [WIDTH-1:0] MeasPeriod,
   output logic [WIDTH-1:0] MeasHigh,
   output logic             Valid,
   output logic             Timeout,
   output logic             StuckLevel,
   output logic             Busy
);

   // state   | meaning
   // ST_IDLE | disabled, timed out, or waiting for the first rising edge
   // ST_HIGH | input high, timing the high phase
   // ST_LOW  | input low, waiting for the rise that closes the period
   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;
   logic [WIDTH-1:0]       cnt;
   logic [WIDTH-1:0]       hi_tmp;
   logic                   s;
   logic                   rise;
   logic                   fall;
   logic                   cnt_sat;

   assign s       = sync_q[SYNC_STAGES-1];
   assign rise    = s & ~s_d;
   assign fall    = ~s & s_d;
   assign cnt_sat = (cnt == CNT_MAX);
   assign Busy    = (state == ST_HIGH) || (state == ST_LOW);

   always_ff @(posedge SysClk) begin
      if (Reset) begin
         state      <= ST_IDLE;
         sync_q     <= '0;
         s_d        <= 1'b0;
         cnt        <= '0;
         hi_tmp     <= '0;
         MeasPeriod <= '0;
         MeasHigh   <= '0;
         Valid      <= 1'b0;
         Timeout    <= 1'b0;
         StuckLevel <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], PwmIn};
         s_d    <= s;
         Valid  <= 1'b0;
         if (!Enable) begin
            state <= ST_IDLE;
         end else begin
            if (rise)
               cnt <= CNT_ONE;
            else if (!cnt_sat)
               cnt <= cnt + CNT_ONE;
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state      <= ST_HIGH;
                     Timeout    <= 1'b0;
                     StuckLevel <= 1'b0;
                  end else if (cnt_sat && !Timeout) begin
                     // capture the level only once so a later fall cannot rewrite it
                     Timeout    <= 1'b1;
                     StuckLevel <= s;
                  end
               end
               ST_HIGH: begin
                  if (fall) begin
                     hi_tmp <= cnt;
                     state  <= ST_LOW;
                  end else if (cnt_sat) begin
                     Timeout    <= 1'b1;
                     StuckLevel <= s;
                     state      <= ST_IDLE;
                  end
               end
               ST_LOW: begin
                  if (rise) begin
                     MeasPeriod <= cnt;
                     MeasHigh   <= hi_tmp;
                     Valid      <= 1'b1;
                     state      <= ST_HIGH;
                  end else if (cnt_sat) begin
                     Timeout    <= 1'b1;
                     StuckLevel <= s;
                     state      <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
